umi_demux_onehot: RTL and testbench

One-hot-select UMI demultiplexer: routes a single UMI request stream (cmd/dstaddr/srcaddr/data with valid/ready) to one of M output ports chosen by a per-transaction select vector. It sits between a UMI source and M downstream UMI clients. In a typical instance the select is decoded from dstaddr bits [40 +: clog2(M)]; that decode is done outside the block. It also provides a sticky select-error flag and an optional output pipeline stage.

---
 rtl/umi_demux_pkg.sv | 24 ++
 rtl/umi_demux_pipe.sv | 80 ++++++++
 rtl/umi_demux_onehot.sv | 93 +++++++++
 tb/tb_umi_demux_onehot.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/umi_demux_pkg.sv
// Shared constants and select helpers for the UMI one-hot demultiplexer.
package umi_demux_pkg;

    localparam int unsigned UMI_DW = 256;
    localparam int unsigned UMI_CW = 32;
    localparam int unsigned UMI_AW = 64;
    localparam int unsigned MAX_M  = 64;

    // Keeps only the lowest set bit; callers cast their M-bit select in and out.
    function automatic logic [MAX_M-1:0] lowest_onehot(input logic [MAX_M-1:0] vec);
        logic [MAX_M-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_M; i++) begin
            if (vec[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/umi_demux_pipe.sv
// Single output register stage for umi_demux_onehot (used when UMI_DEMUX_PIPE_EN is defined).
module umi_demux_pipe #(
    parameter int unsigned M  = 4,
    parameter int unsigned DW = 256,
    parameter int unsigned CW = 32,
    parameter int unsigned AW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [M-1:0]  in_sel,
    input  logic [CW-1:0] in_cmd,
    input  logic [AW-1:0] in_dstaddr,
    input  logic [AW-1:0] in_srcaddr,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [M-1:0]  out_valid,
    output logic [CW-1:0] out_cmd,
    output logic [AW-1:0] out_dstaddr,
    output logic [AW-1:0] out_srcaddr,
    output logic [DW-1:0] out_data,
    input  logic [M-1:0]  out_ready
);

    logic          full_d, full_q;
    logic [M-1:0]  sel_d, sel_q;
    logic [CW-1:0] cmd_d, cmd_q;
    logic [AW-1:0] dst_d, dst_q;
    logic [AW-1:0] src_d, src_q;
    logic [DW-1:0] data_d, data_q;
    logic          drain;
    logic          load;

    always_comb begin
        drain    = full_q & (|(sel_q & out_ready));
        in_ready = !full_q | drain;
        // A zero select is accepted when empty but never loaded, so it is dropped.
        load     = in_valid & in_ready & (|in_sel);
        full_d   = full_q;
        sel_d    = sel_q;
        cmd_d    = cmd_q;
        dst_d    = dst_q;
        src_d    = src_q;
        data_d   = data_q;
        if (load) begin
            full_d = 1'b1;
            sel_d  = in_sel;
            cmd_d  = in_cmd;
            dst_d  = in_dstaddr;
            src_d  = in_srcaddr;
            data_d = in_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_q  <= cmd_d;
        dst_q  <= dst_d;
        src_q  <= src_d;
        data_q <= data_d;
    end

    assign out_valid   = {M{full_q}} & sel_q;
    assign out_cmd     = cmd_q;
    assign out_dstaddr = dst_q;
    assign out_srcaddr = src_q;
    assign out_data    = data_q;

endmodule

// File: rtl/umi_demux_onehot.sv
// One-hot-select UMI demultiplexer with sticky select-error flag.
// Define UMI_DEMUX_PIPE_EN to add one registered output stage (1-cycle latency).
module umi_demux_onehot
    import umi_demux_pkg::*;
#(
    parameter int unsigned M  = 4,
    parameter int unsigned DW = UMI_DW,
    parameter int unsigned CW = UMI_CW,
    parameter int unsigned AW = UMI_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [M-1:0]    select,
    input  logic            umi_in_valid,
    input  logic [CW-1:0]   umi_in_cmd,
    input  logic [AW-1:0]   umi_in_dstaddr,
    input  logic [AW-1:0]   umi_in_srcaddr,
    input  logic [DW-1:0]   umi_in_data,
    output logic            umi_in_ready,
    output logic [M-1:0]    umi_out_valid,
    output logic [M*CW-1:0] umi_out_cmd,
    output logic [M*AW-1:0] umi_out_dstaddr,
    output logic [M*AW-1:0] umi_out_srcaddr,
    output logic [M*DW-1:0] umi_out_data,
    input  logic [M-1:0]    umi_out_ready,
    output logic            sel_err
);

    logic [M-1:0]  sel_eff;
    logic          sel_err_d, sel_err_q;
    logic [CW-1:0] cmd_s;
    logic [AW-1:0] dst_s;
    logic [AW-1:0] src_s;
    logic [DW-1:0] data_s;

    assign sel_eff = M'(lowest_onehot(MAX_M'(select)));

    always_comb begin
        sel_err_d = sel_err_q;
        if (umi_in_valid && ((select == '0) || (select != sel_eff))) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

`ifdef UMI_DEMUX_PIPE_EN
    umi_demux_pipe #(
        .M  (M),
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (umi_in_valid),
        .in_sel      (sel_eff),
        .in_cmd      (umi_in_cmd),
        .in_dstaddr  (umi_in_dstaddr),
        .in_srcaddr  (umi_in_srcaddr),
        .in_data     (umi_in_data),
        .in_ready    (umi_in_ready),
        .out_valid   (umi_out_valid),
        .out_cmd     (cmd_s),
        .out_dstaddr (dst_s),
        .out_srcaddr (src_s),
        .out_data    (data_s),
        .out_ready   (umi_out_ready)
    );
`else
    assign umi_out_valid = {M{umi_in_valid}} & sel_eff;
    assign umi_in_ready  = |(sel_eff & umi_out_ready);
    assign cmd_s         = umi_in_cmd;
    assign dst_s         = umi_in_dstaddr;
    assign src_s         = umi_in_srcaddr;
    assign data_s        = umi_in_data;
`endif

    // Payload is broadcast; only valid distinguishes the destination port.
    assign umi_out_cmd     = {M{cmd_s}};
    assign umi_out_dstaddr = {M{dst_s}};
    assign umi_out_srcaddr = {M{src_s}};
    assign umi_out_data    = {M{data_s}};

endmodule

// File: tb/tb_umi_demux_onehot.sv
// Directed self-checking bench for umi_demux_onehot; covers pipelined mode when UMI_DEMUX_PIPE_EN is defined.
module tb_umi_demux_onehot;

    localparam int unsigned M  = 4;
    localparam int unsigned DW = 256;
    localparam int unsigned CW = 32;
    localparam int unsigned AW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [M-1:0]    select;
    logic            umi_in_valid;
    logic [CW-1:0]   umi_in_cmd;
    logic [AW-1:0]   umi_in_dstaddr;
    logic [AW-1:0]   umi_in_srcaddr;
    logic [DW-1:0]   umi_in_data;
    logic            umi_in_ready;
    logic [M-1:0]    umi_out_valid;
    logic [M*CW-1:0] umi_out_cmd;
    logic [M*AW-1:0] umi_out_dstaddr;
    logic [M*AW-1:0] umi_out_srcaddr;
    logic [M*DW-1:0] umi_out_data;
    logic [M-1:0]    umi_out_ready;
    logic            sel_err;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    umi_demux_onehot #(
        .M  (M),
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .select          (select),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .sel_err         (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int unsigned k);
        logic [31:0] w;
        w = 32'hD0D0_0000 | k;
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slices(input string tag, input int unsigned k,
                                input logic [CW-1:0] c, input logic [AW-1:0] d,
                                input logic [AW-1:0] s, input logic [DW-1:0] x);
        check({tag, "_cmd"},  256'(umi_out_cmd[k*CW +: CW]),     256'(c));
        check({tag, "_dst"},  256'(umi_out_dstaddr[k*AW +: AW]), 256'(d));
        check({tag, "_src"},  256'(umi_out_srcaddr[k*AW +: AW]), 256'(s));
        check({tag, "_data"}, 256'(umi_out_data[k*DW +: DW]),    256'(x));
    endtask

    initial begin
        reset          = 1'b1;
        umi_in_valid   = 1'b1;
        select         = 4'b0100;
        umi_out_ready  = 4'b0000;
        umi_in_cmd     = 32'h0000_1234;
        umi_in_dstaddr = 64'h0000_0200_0000_0000;
        umi_in_srcaddr = 64'h0000_0000_CAFE_0000;
        umi_in_data    = pat(32'h77);
        #12;
        check("rst_sel_err", 256'(sel_err), 256'(1'b0));
`ifdef UMI_DEMUX_PIPE_EN
        check("rst_pipe_valid", 256'(umi_out_valid), 256'(4'b0000));
        umi_in_valid = 1'b0;
        reset = 1'b0;
        umi_out_ready = 4'b1111;

        // Back-to-back to ports 0..3; each shows up one cycle after acceptance.
        for (int unsigned k = 0; k < M; k++) begin
            tick();
            umi_in_valid = 1'b1;
            select       = 4'(1 << k);
            umi_in_cmd   = 32'h100 + k;
            umi_in_data  = pat(k);
            #1;
            check($sformatf("b2b_ready_%0d", k), 256'(umi_in_ready), 256'(1'b1));
            check($sformatf("b2b_valid_%0d", k), 256'(umi_out_valid),
                  (k == 0) ? 256'(0) : 256'(4'(1 << (k - 1))));
            if (k > 0) begin
                check($sformatf("b2b_data_%0d", k), 256'(umi_out_data[(k-1)*DW +: DW]), 256'(pat(k - 1)));
                check($sformatf("b2b_cmd_%0d", k), 256'(umi_out_cmd[(k-1)*CW +: CW]), 256'(32'h100 + k - 1));
            end
        end
        tick();
        umi_in_valid = 1'b0;
        #1;
        check("last_valid", 256'(umi_out_valid), 256'(4'b1000));
        check("last_data", 256'(umi_out_data[3*DW +: DW]), 256'(pat(3)));

        umi_out_ready = 4'b0111;
        umi_in_valid  = 1'b1;
        select        = 4'b0001;
        umi_in_data   = pat(9);
        #1;
        check("stall_ready", 256'(umi_in_ready), 256'(1'b0));
        tick();
        check("stall_hold_valid", 256'(umi_out_valid), 256'(4'b1000));
        check("stall_hold_data", 256'(umi_out_data[3*DW +: DW]), 256'(pat(3)));
        select = 4'b0000;
        tick();
        check("pipe_zero_err", 256'(sel_err), 256'(1'b1));
        check("pipe_zero_hold", 256'(umi_out_valid), 256'(4'b1000));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_valid", 256'(umi_out_valid), 256'(4'b0000));
        check("midrst_sel_err", 256'(sel_err), 256'(1'b0));
        check("midrst_ready", 256'(umi_in_ready), 256'(1'b1));
        reset = 1'b0;
`else
        check("rst_base_valid", 256'(umi_out_valid), 256'(4'b0100));
        reset = 1'b0;
        tick();

        umi_out_ready = 4'b1111;
        #1;
        check("t1_valid", 256'(umi_out_valid), 256'(4'b0100));
        check("t1_ready", 256'(umi_in_ready), 256'(1'b1));
        for (int unsigned k = 0; k < M; k++) begin
            check_slices($sformatf("t1_slice%0d", k), k, 32'h0000_1234,
                         64'h0000_0200_0000_0000, 64'h0000_0000_CAFE_0000, pat(32'h77));
        end
        tick();
        check("t1_sel_err", 256'(sel_err), 256'(1'b0));

        select        = 4'b0010;
        umi_out_ready = 4'b1101;
        #1;
        check("t2_valid", 256'(umi_out_valid), 256'(4'b0010));
        check("t2_stall", 256'(umi_in_ready), 256'(1'b0));
        umi_out_ready = 4'b1111;
        #1;
        check("t2_accept", 256'(umi_in_ready), 256'(1'b1));
        tick();

        select = 4'b1100;
        #1;
        check("t3_lsb_valid", 256'(umi_out_valid), 256'(4'b0100));
        tick();
        check("t3_multi_err", 256'(sel_err), 256'(1'b1));
        reset = 1'b1;
        #1;
        check("t3_rst_clear", 256'(sel_err), 256'(1'b0));
        reset = 1'b0;

        umi_in_valid = 1'b0;
        select       = 4'b0000;
        tick();
        select = 4'b0111;
        tick();
        check("idle_no_err", 256'(sel_err), 256'(1'b0));
        check("idle_valid", 256'(umi_out_valid), 256'(4'b0000));

        umi_in_valid = 1'b1;
        select       = 4'b0000;
        #1;
        check("zero_valid", 256'(umi_out_valid), 256'(4'b0000));
        check("zero_ready", 256'(umi_in_ready), 256'(1'b0));
        check("zero_err_pre", 256'(sel_err), 256'(1'b0));
        tick();
        check("zero_err_set", 256'(sel_err), 256'(1'b1));
        umi_in_valid = 1'b0;
        select       = 4'b0001;
        tick();
        tick();
        check("zero_err_sticky", 256'(sel_err), 256'(1'b1));
        reset = 1'b1;
        #1;
        check("zero_rst_clear", 256'(sel_err), 256'(1'b0));
        reset = 1'b0;
        tick();

        umi_in_valid = 1'b1;
        select       = 4'b1010;
        #1;
        check("t6_valid", 256'(umi_out_valid), 256'(4'b0010));
        check("t6_ready", 256'(umi_in_ready), 256'(1'b1));
        tick();
        check("t6_err", 256'(sel_err), 256'(1'b1));
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
